// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: display reads vs. CPU posted writes and ordered reads.
// Display wins during active video, CPU wins in vblank, starvation counter forces CPU slots.
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wr_pending,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PTR_W    = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    wr_entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                disp_rvalid_q, cpu_rvalid_q, wr_pending_q;

    logic      has_wr, has_rd, cpu_cand, cpu_win, disp_win;
    logic      push, pop, rd_gnt;
    wr_entry_t head;

    // Candidate selection, arbitration, FIFO bookkeeping and RAM port mux
    always_comb begin
        has_wr    = 1'b0;
        has_rd    = 1'b0;
        cpu_cand  = 1'b0;
        cpu_win   = 1'b0;
        disp_win  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        rd_gnt    = 1'b0;
        head      = fifo_q[rd_ptr_q];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        disp_gnt  = 1'b0;
        cpu_gnt   = 1'b0;

        has_wr   = (count_q != '0);
        has_rd   = !has_wr && cpu_req && !cpu_we;
        cpu_cand = has_wr || has_rd;

        if (vblank || (starve_q == STARVE_W'(STARVE_MAX))) begin
            cpu_win  = cpu_cand;
            disp_win = !cpu_cand && disp_req;
        end else begin
            disp_win = disp_req;
            cpu_win  = !disp_req && cpu_cand;
        end

        // No RAM access or grant is visible while reset is asserted
        if (!rst) begin
            cpu_win  = 1'b0;
            disp_win = 1'b0;
        end

        push   = rst && cpu_req && cpu_we && (count_q < CNT_W'(DEPTH));
        pop    = cpu_win && has_wr;
        rd_gnt = cpu_win && has_rd;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        if (cpu_cand && !cpu_win) begin
            starve_d = (starve_q == STARVE_W'(STARVE_MAX)) ? starve_q
                                                           : starve_q + STARVE_W'(1);
        end

        mem_en   = cpu_win || disp_win;
        mem_we   = pop;
        disp_gnt = disp_win;
        cpu_gnt  = push || rd_gnt;
        if (pop) begin
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end else if (rd_gnt) begin
            mem_addr = cpu_addr;
        end else if (disp_win) begin
            mem_addr = disp_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            starve_q      <= '0;
            disp_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            wr_pending_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            starve_q      <= starve_d;
            disp_rvalid_q <= disp_win;
            cpu_rvalid_q  <= rd_gnt;
            wr_pending_q  <= (count_d != '0);
        end
    end

    // Storage needs no reset: entries are only read behind a valid count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: cpu_addr, data: cpu_wdata};
        end
    end

    assign disp_rvalid    = disp_rvalid_q;
    assign cpu_rvalid     = cpu_rvalid_q;
    assign cpu_wr_pending = wr_pending_q;
    assign disp_rdata     = mem_rdata;
    assign cpu_rdata      = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        disp_req;
    logic [14:0] disp_addr;
    logic        disp_gnt, disp_rvalid;
    logic [11:0] disp_rdata;
    logic        cpu_req, cpu_we;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [11:0] cpu_rdata;
    logic        cpu_wr_pending;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;

    logic [11:0] ram [0:32767];

    int checks   = 0;
    int failures = 0;

    vram_arbiter #(.ADDR_W(15), .DATA_W(12), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst), .vblank(vblank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_wr_pending(cpu_wr_pending),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Inputs change just after the falling edge; outputs are sampled 1ns later
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic dr, input logic [14:0] da, input logic cr,
                         input logic we, input logic [14:0] ca, input logic [11:0] cd);
        disp_req  = dr;
        disp_addr = da;
        cpu_req   = cr;
        cpu_we    = we;
        cpu_addr  = ca;
        cpu_wdata = cd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic test_reset();
        cyc();
        drive(1'b1, 15'h0001, 1'b1, 1'b1, 15'h0002, 12'h123);
        #1;
        checks++;
        if ({mem_en, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, cpu_wr_pending} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {mem_en, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, cpu_wr_pending});
        end
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        cyc();
        #1;
        checks++;
        if ({mem_en, disp_rvalid, cpu_wr_pending} !== 3'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got %b expected 000",
                     {mem_en, disp_rvalid, cpu_wr_pending});
        end
    endtask

    task automatic test_display_stream();
        logic exp_gnt, exp_rv;
        for (int c = 0; c < 6; c++) begin
            cyc();
            drive(c < 4, 15'(c), 1'b0, 1'b0, '0, '0);
            #1;
            exp_gnt = (c < 4);
            exp_rv  = (c >= 1) && (c <= 4);
            checks++;
            if (disp_gnt !== exp_gnt || mem_en !== exp_gnt) begin
                failures++;
                $display("FAIL disp_gnt c=%0d: got gnt=%b en=%b expected %b", c, disp_gnt, mem_en, exp_gnt);
            end
            if (exp_gnt) begin
                checks++;
                if (mem_addr !== 15'(c) || mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL disp_addr c=%0d: got addr=%h we=%b expected %h we=0", c, mem_addr, mem_we, c);
                end
            end
            checks++;
            if (disp_rvalid !== exp_rv || cpu_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL disp_rvalid c=%0d: got %b/%b expected %b/0", c, disp_rvalid, cpu_rvalid, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (disp_rdata !== 12'hA00 + 12'(c - 1)) begin
                    failures++;
                    $display("FAIL disp_rdata c=%0d: got %h expected %h", c, disp_rdata, 12'hA00 + 12'(c - 1));
                end
            end
        end
    endtask

    task automatic test_starvation();
        cyc();
        drive(1'b1, 15'h0100, 1'b1, 1'b1, 15'h0010, 12'h0F0);
        #1;
        checks++;
        if (cpu_gnt !== 1'b1 || disp_gnt !== 1'b1) begin
            failures++;
            $display("FAIL starve_push: got cpu_gnt=%b disp_gnt=%b expected 1/1", cpu_gnt, disp_gnt);
        end
        for (int c = 1; c <= 8; c++) begin
            cyc();
            drive(1'b1, 15'h0100, 1'b0, 1'b0, '0, '0);
            #1;
            checks++;
            if (disp_gnt !== 1'b1 || mem_we !== 1'b0 || cpu_wr_pending !== 1'b1) begin
                failures++;
                $display("FAIL starve_wait c=%0d: got gnt=%b we=%b pend=%b expected 1/0/1",
                         c, disp_gnt, mem_we, cpu_wr_pending);
            end
        end
        cyc();
        #1;
        checks++;
        if (disp_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== 15'h0010 || mem_wdata !== 12'h0F0) begin
            failures++;
            $display("FAIL starve_forced: got gnt=%b en=%b we=%b addr=%h data=%h expected 0/1/1/0010/0f0",
                     disp_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        cyc();
        #1;
        checks++;
        if (cpu_wr_pending !== 1'b0 || disp_gnt !== 1'b1) begin
            failures++;
            $display("FAIL starve_after: got pend=%b gnt=%b expected 0/1", cpu_wr_pending, disp_gnt);
        end
        idle(2);
    endtask

    task automatic test_fifo_full();
        int   k = 0;
        logic exp_gnt;
        bit   drained = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            cyc();
            drive(1'b1, 15'h0200, k < 5, 1'b1, 15'h0040 + 15'(k), 12'h300 + 12'(k));
            #1;
            exp_gnt = (c < 4) || (c == 10);
            checks++;
            if (cpu_gnt !== exp_gnt) begin
                failures++;
                $display("FAIL fifo_gnt c=%0d: got %b expected %b", c, cpu_gnt, exp_gnt);
            end
            if (c == 9) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 15'h0040 || mem_wdata !== 12'h300) begin
                    failures++;
                    $display("FAIL fifo_first_pop: got we=%b addr=%h data=%h expected 1/0040/300",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (cpu_gnt === 1'b1) k++;
        end
        for (int i = 0; i < 20 && !drained; i++) begin
            cyc();
            drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
            #1;
            if (cpu_wr_pending === 1'b0) drained = 1'b1;
        end
        checks++;
        if (!drained) begin
            failures++;
            $display("FAIL fifo_drain_timeout: got pending=%b expected 0 within 20 cycles", cpu_wr_pending);
        end
        idle(1);
        checks++;
        if (ram[15'h0044] !== 12'h304 || ram[15'h0040] !== 12'h300) begin
            failures++;
            $display("FAIL fifo_ram_contents: got %h/%h expected 300/304", ram[15'h0040], ram[15'h0044]);
        end
    endtask

    task automatic test_vblank_priority();
        vblank = 1'b1;
        cyc();
        drive(1'b0, '0, 1'b1, 1'b1, 15'h0050, 12'h555);
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            failures++;
            $display("FAIL vblank_push: got cpu_gnt=%b expected 1", cpu_gnt);
        end
        cyc();
        drive(1'b1, 15'h0002, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (disp_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 15'h0050) begin
            failures++;
            $display("FAIL vblank_cpu_first: got gnt=%b we=%b addr=%h expected 0/1/0050", disp_gnt, mem_we, mem_addr);
        end
        cyc();
        #1;
        checks++;
        if (disp_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'h0002) begin
            failures++;
            $display("FAIL vblank_disp_next: got gnt=%b we=%b addr=%h expected 1/0/0002", disp_gnt, mem_we, mem_addr);
        end
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 12'hA02) begin
            failures++;
            $display("FAIL vblank_disp_data: got rv=%b data=%h expected 1/a02", disp_rvalid, disp_rdata);
        end
        vblank = 1'b0;
        idle(1);
    endtask

    task automatic test_read_ordering();
        cyc();
        drive(1'b0, '0, 1'b1, 1'b1, 15'h0020, 12'h155);
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            failures++;
            $display("FAIL order_push: got cpu_gnt=%b expected 1", cpu_gnt);
        end
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0, 15'h0020, '0);
        #1;
        checks++;
        if (cpu_gnt !== 1'b0 || mem_we !== 1'b1 || cpu_wr_pending !== 1'b1) begin
            failures++;
            $display("FAIL order_read_held: got gnt=%b we=%b pend=%b expected 0/1/1", cpu_gnt, mem_we, cpu_wr_pending);
        end
        cyc();
        #1;
        checks++;
        if (cpu_wr_pending !== 1'b0 || cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
            mem_addr !== 15'h0020) begin
            failures++;
            $display("FAIL order_read_issue: got pend=%b gnt=%b en=%b we=%b addr=%h expected 0/1/1/0/0020",
                     cpu_wr_pending, cpu_gnt, mem_en, mem_we, mem_addr);
        end
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 12'h155 || disp_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL order_read_data: got rv=%b data=%h drv=%b expected 1/155/0", cpu_rvalid, cpu_rdata, disp_rvalid);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 3; c++) begin
            cyc();
            drive(1'b1, 15'h0000, 1'b1, 1'b1, 15'h0060 + 15'(c), 12'h700 + 12'(c));
            #1;
            checks++;
            if (cpu_gnt !== 1'b1) begin
                failures++;
                $display("FAIL burst_push c=%0d: got cpu_gnt=%b expected 1", c, cpu_gnt);
            end
        end
        cyc();
        drive(1'b1, 15'h0001, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (disp_gnt !== 1'b1 || cpu_wr_pending !== 1'b1) begin
            failures++;
            $display("FAIL burst_inflight: got gnt=%b pend=%b expected 1/1", disp_gnt, cpu_wr_pending);
        end
        #1;
        rst = 1'b0;
        cyc();
        drive(1'b1, 15'h0001, 1'b1, 1'b1, 15'h0070, 12'h777);
        #1;
        checks++;
        if ({mem_en, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, cpu_wr_pending} !== 6'b0) begin
            failures++;
            $display("FAIL burst_in_reset: got %b expected 000000",
                     {mem_en, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, cpu_wr_pending});
        end
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            checks++;
            if ({mem_en, disp_rvalid, cpu_rvalid, cpu_wr_pending} !== 4'b0) begin
                failures++;
                $display("FAIL burst_after_reset c=%0d: got %b expected 0000",
                         c, {mem_en, disp_rvalid, cpu_rvalid, cpu_wr_pending});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ram[i] = 12'hA00 + 12'(i);
        rst    = 1'b0;
        vblank = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        test_reset();
        test_display_stream();
        idle(1);
        test_starvation();
        test_fifo_full();
        test_vblank_priority();
        test_read_ordering();
        test_reset_mid_burst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
